noc_dmem_requester: RTL and testbench

- Sits between the SCR1 LSU data-memory port and the NoC splitter/packet_collector pair.
- Converts one outstanding remote dmem request into a request packet with destination node and packet ID, then hands it to the splitter.
- Waits for the matching response packet from the collector and returns rdata and resp to the LSU.
- Single outstanding transaction; stray or mismatched responses are consumed and dropped.

---
 rtl/noc_dmem_requester.sv | 193 +++++++++++++++++++
 tb/tb_noc_dmem_requester.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_dmem_requester.sv
// noc_dmem_requester: bridges one outstanding LSU dmem request onto the NoC.
// Builds a tagged request packet, waits for the matching response, replies to the LSU.
module noc_dmem_requester #(
    parameter int NODE_COUNT      = 9,
    parameter int PACKET_ID_WIDTH = 5,
    parameter int REGION_BYTES    = 4096,
    parameter int AW              = 32,
    parameter int DW              = 32,
    parameter int TIMEOUT_CYCLES  = 1024,
    localparam int NODE_W         = $clog2(NODE_COUNT),
    localparam int PACKET_W       = 4 + AW + DW
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       lsu_req_i,
    input  logic                       lsu_cmd_i,
    input  logic [1:0]                 lsu_width_i,
    input  logic [AW-1:0]              lsu_addr_i,
    input  logic [DW-1:0]              lsu_wdata_i,
    output logic                       lsu_req_ack_o,
    output logic [DW-1:0]              lsu_rdata_o,
    output logic [1:0]                 lsu_resp_o,
    output logic [PACKET_W-1:0]        spl_packet_o,
    output logic [NODE_W-1:0]          spl_node_dest_o,
    output logic [PACKET_ID_WIDTH-1:0] spl_packet_id_o,
    output logic                       spl_valid_o,
    input  logic                       spl_ack_i,
    input  logic                       col_valid_i,
    input  logic [PACKET_W-1:0]        col_packet_i,
    input  logic [NODE_W-1:0]          col_node_start_i,
    input  logic [PACKET_ID_WIDTH-1:0] col_packet_id_i,
    output logic                       col_read_o,
    output logic [15:0]                drop_cnt_o
);

    localparam int SHIFT = $clog2(REGION_BYTES);
    localparam int TW    = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [1:0] T_RD_REQ  = 2'b00;
    localparam logic [1:0] T_WR_REQ  = 2'b01;
    localparam logic [1:0] T_RD_RESP = 2'b10;
    localparam logic [1:0] T_WR_ACK  = 2'b11;

    localparam logic [1:0] R_NOTRDY = 2'b00;
    localparam logic [1:0] R_OK     = 2'b01;
    localparam logic [1:0] R_ER     = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT,
        RESP
    } state_t;

    state_t                     state_q;
    state_t                     state_d;
    logic [PACKET_ID_WIDTH-1:0] id_cnt_q;
    logic [PACKET_ID_WIDTH-1:0] tag_q;
    logic [NODE_W-1:0]          dest_q;
    logic [PACKET_W-1:0]        pkt_q;
    logic                       cmd_q;
    logic [1:0]                 resp_q;
    logic [DW-1:0]              rdata_q;
    logic [15:0]                drop_q;
    logic [TW-1:0]              tmo_q;

    logic [AW-1:0]              dest_full;
    logic                       oor;
    logic                       accept;
    logic                       xfer;
    logic                       match;
    logic                       timeout;
    logic [1:0]                 exp_type;
    logic [1:0]                 col_type;
    logic                       unused_bits;

    assign dest_full = lsu_addr_i >> SHIFT;
    assign oor       = dest_full >= AW'(NODE_COUNT);
    assign accept    = lsu_req_i && (state_q == IDLE);
    assign xfer      = (state_q == SEND) && spl_ack_i;
    assign exp_type  = cmd_q ? T_WR_ACK : T_RD_RESP;
    assign col_type  = col_packet_i[PACKET_W-1 -: 2];
    assign timeout   = tmo_q == TW'(TIMEOUT_CYCLES - 1);

    assign match = (state_q == WAIT)
                && col_valid_i
                && (col_node_start_i == dest_q)
                && (col_packet_id_i == tag_q)
                && (col_type == exp_type);

    // Width and address fields of responses are not needed.
    assign unused_bits = ^col_packet_i[PACKET_W-3:DW];

    assign lsu_req_ack_o   = (state_q == IDLE);
    assign lsu_resp_o      = (state_q == RESP) ? resp_q : R_NOTRDY;
    assign lsu_rdata_o     = rdata_q;
    assign spl_valid_o     = (state_q == SEND);
    assign spl_packet_o    = pkt_q;
    assign spl_node_dest_o = dest_q;
    assign spl_packet_id_o = tag_q;
    assign col_read_o      = col_valid_i;
    assign drop_cnt_o      = drop_q;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a match wins over a timeout in the same cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = oor ? RESP : SEND;
                end
            end
            SEND: begin
                if (spl_ack_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (match || timeout) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request capture, tag counter, timeout counter and response data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            id_cnt_q <= '0;
            tag_q    <= '0;
            dest_q   <= '0;
            pkt_q    <= '0;
            cmd_q    <= 1'b0;
            resp_q   <= R_NOTRDY;
            rdata_q  <= '0;
            tmo_q    <= '0;
        end else begin
            if (accept) begin
                cmd_q <= lsu_cmd_i;
                if (oor) begin
                    resp_q  <= R_ER;
                    rdata_q <= '0;
                end else begin
                    dest_q <= dest_full[NODE_W-1:0];
                    tag_q  <= id_cnt_q;
                    pkt_q  <= {lsu_cmd_i ? T_WR_REQ : T_RD_REQ,
                               lsu_width_i,
                               lsu_addr_i,
                               lsu_cmd_i ? lsu_wdata_i : '0};
                end
            end
            if (xfer) begin
                id_cnt_q <= id_cnt_q + PACKET_ID_WIDTH'(1);
                tmo_q    <= '0;
            end
            if (state_q == WAIT) begin
                tmo_q <= tmo_q + TW'(1);
                if (match) begin
                    resp_q  <= R_OK;
                    rdata_q <= cmd_q ? '0 : col_packet_i[DW-1:0];
                end else if (timeout) begin
                    resp_q  <= R_ER;
                    rdata_q <= '0;
                end
            end
        end
    end

    // Saturating count of popped packets that did not complete a request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_q <= '0;
        end else if (col_valid_i && !match && (drop_q != 16'hFFFF)) begin
            drop_q <= drop_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_noc_dmem_requester.sv
// tb_noc_dmem_requester: directed bench with a response scoreboard.
// Uses a short timeout so the timeout path is reached quickly.
module tb_noc_dmem_requester;

    localparam int PW = 68;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          lsu_req_i;
    logic          lsu_cmd_i;
    logic [1:0]    lsu_width_i;
    logic [31:0]   lsu_addr_i;
    logic [31:0]   lsu_wdata_i;
    logic          lsu_req_ack_o;
    logic [31:0]   lsu_rdata_o;
    logic [1:0]    lsu_resp_o;
    logic [PW-1:0] spl_packet_o;
    logic [3:0]    spl_node_dest_o;
    logic [4:0]    spl_packet_id_o;
    logic          spl_valid_o;
    logic          spl_ack_i;
    logic          col_valid_i;
    logic [PW-1:0] col_packet_i;
    logic [3:0]    col_node_start_i;
    logic [4:0]    col_packet_id_i;
    logic          col_read_o;
    logic [15:0]   drop_cnt_o;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] rdata;
        bit          chk_data;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    noc_dmem_requester #(
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .lsu_req_i        (lsu_req_i),
        .lsu_cmd_i        (lsu_cmd_i),
        .lsu_width_i      (lsu_width_i),
        .lsu_addr_i       (lsu_addr_i),
        .lsu_wdata_i      (lsu_wdata_i),
        .lsu_req_ack_o    (lsu_req_ack_o),
        .lsu_rdata_o      (lsu_rdata_o),
        .lsu_resp_o       (lsu_resp_o),
        .spl_packet_o     (spl_packet_o),
        .spl_node_dest_o  (spl_node_dest_o),
        .spl_packet_id_o  (spl_packet_id_o),
        .spl_valid_o      (spl_valid_o),
        .spl_ack_i        (spl_ack_i),
        .col_valid_i      (col_valid_i),
        .col_packet_i     (col_packet_i),
        .col_node_start_i (col_node_start_i),
        .col_packet_id_i  (col_packet_id_i),
        .col_read_o       (col_read_o),
        .drop_cnt_o       (drop_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] r, input logic [31:0] d,
                        input bit c);
        exp_t e;
        e.resp     = r;
        e.rdata    = d;
        e.chk_data = c;
        sb.push_back(e);
    endtask

    task automatic issue(input logic cmd, input logic [1:0] w,
                         input logic [31:0] a, input logic [31:0] d);
        lsu_req_i   = 1'b1;
        lsu_cmd_i   = cmd;
        lsu_width_i = w;
        lsu_addr_i  = a;
        lsu_wdata_i = d;
        chk("req_ack", lsu_req_ack_o, 1);
        step();
        lsu_req_i = 1'b0;
    endtask

    task automatic ack();
        spl_ack_i = 1'b1;
        step();
        spl_ack_i = 1'b0;
    endtask

    task automatic respond(input logic [1:0] t, input logic [31:0] d,
                           input logic [3:0] node, input logic [4:0] id);
        col_valid_i      = 1'b1;
        col_packet_i     = {t, 2'b10, 32'h0, d};
        col_node_start_i = node;
        col_packet_id_i  = id;
        chk("col_read", col_read_o, 1);
        step();
        col_valid_i = 1'b0;
    endtask

    task automatic wait_resp(input string tag, input int budget);
        exp_t e;
        int   n = 0;
        while (lsu_resp_o == 2'b00 && n < budget) begin
            step();
            n++;
        end
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, sb.size(), 1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_resp"}, lsu_resp_o, e.resp);
            if (e.chk_data) begin
                chk({tag, "_rdata"}, lsu_rdata_o, e.rdata);
            end
            step();
            chk({tag, "_resp_drop"}, lsu_resp_o, 0);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        lsu_req_i    = 1'b0;
        lsu_cmd_i    = 1'b0;
        lsu_width_i  = 2'b00;
        lsu_addr_i   = '0;
        lsu_wdata_i  = '0;
        spl_ack_i    = 1'b0;
        col_valid_i  = 1'b0;
        col_packet_i = '0;
        col_node_start_i = '0;
        col_packet_id_i  = '0;
        step();
        step();
        rst_n = 1'b1;

        chk("rst_valid", spl_valid_o, 0);
        chk("rst_resp", lsu_resp_o, 0);
        chk("rst_rdata", lsu_rdata_o, 0);
        chk("rst_pkt", spl_packet_o, 0);
        chk("rst_dest", spl_node_dest_o, 0);
        chk("rst_id", spl_packet_id_o, 0);
        chk("rst_drop", drop_cnt_o, 0);

        // Read from node 2.
        issue(1'b0, 2'b10, 32'h0000_2010, 32'hFFFF_FFFF);
        push(2'b01, 32'hDEAD_BEEF, 1);
        chk("rd_valid", spl_valid_o, 1);
        chk("rd_ack_low", lsu_req_ack_o, 0);
        chk("rd_dest", spl_node_dest_o, 2);
        chk("rd_id", spl_packet_id_o, 0);
        chk("rd_pkt", spl_packet_o, {2'b00, 2'b10, 32'h2010, 32'h0});
        ack();
        chk("rd_valid_off", spl_valid_o, 0);
        respond(2'b10, 32'hDEAD_BEEF, 4'd2, 5'd0);
        wait_resp("rd1", 0);
        chk("rd_hold", lsu_rdata_o, 32'hDEAD_BEEF);

        // Write to node 1 with a stalled splitter.
        issue(1'b1, 2'b10, 32'h0000_1004, 32'h1234_5678);
        push(2'b01, 32'h0, 1);
        for (int i = 0; i < 5; i++) begin
            chk("wr_stall_valid", spl_valid_o, 1);
            chk("wr_stall_pkt", spl_packet_o,
                {2'b01, 2'b10, 32'h1004, 32'h1234_5678});
            step();
        end
        chk("wr_pkt6", spl_packet_o, {2'b01, 2'b10, 32'h1004, 32'h1234_5678});
        chk("wr_dest", spl_node_dest_o, 1);
        chk("wr_id", spl_packet_id_o, 1);
        ack();
        respond(2'b11, 32'hFFFF_FFFF, 4'd1, 5'd1);
        wait_resp("wr1", 0);

        // Out-of-range address: no packet, immediate error.
        issue(1'b0, 2'b10, 32'h0000_9000, 32'h0);
        push(2'b10, 32'h0, 1);
        chk("oor_valid", spl_valid_o, 0);
        wait_resp("oor", 0);
        chk("oor_valid2", spl_valid_o, 0);

        // Stray packet while idle is dropped.
        respond(2'b10, 32'h1, 4'd0, 5'd0);
        chk("idle_drop", drop_cnt_o, 1);

        // Wrong tag is dropped, then the correct one completes.
        issue(1'b0, 2'b00, 32'h0000_0040, 32'h0);
        push(2'b01, 32'hCAFE_0001, 1);
        chk("mm_id", spl_packet_id_o, 2);
        ack();
        respond(2'b10, 32'h5555_5555, 4'd0, 5'd3);
        chk("mm_drop", drop_cnt_o, 2);
        chk("mm_nresp", lsu_resp_o, 0);
        respond(2'b10, 32'hCAFE_0001, 4'd0, 5'd2);
        wait_resp("mm", 0);
        chk("mm_drop2", drop_cnt_o, 2);

        // Timeout after 16 WAIT cycles.
        issue(1'b0, 2'b10, 32'h0000_3000, 32'h0);
        push(2'b10, 32'h0, 0);
        ack();
        for (int i = 0; i < 16; i++) begin
            chk("tmo_wait", lsu_resp_o, 0);
            step();
        end
        wait_resp("tmo", 0);

        // Back-to-back reads from a fresh tag counter.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 33; i++) begin
            logic [3:0]  nd;
            logic [4:0]  id;
            logic [31:0] d;
            nd = 4'(i % 9);
            id = 5'(i % 32);
            d  = 32'hA500_0000 + 32'(i);
            issue(1'b0, 2'b10, {16'h0, nd, 12'(i * 4)}, 32'h0);
            push(2'b01, d, 1);
            chk("b2b_id", spl_packet_id_o, id);
            chk("b2b_dest", spl_node_dest_o, nd);
            ack();
            respond(2'b10, d, nd, id);
            wait_resp("b2b", 0);
        end

        // Reset while waiting abandons the transaction.
        issue(1'b0, 2'b10, 32'h0000_1000, 32'h0);
        chk("rw_id", spl_packet_id_o, 1);
        ack();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("rw_resp", lsu_resp_o, 0);
            chk("rw_valid", spl_valid_o, 0);
            step();
        end
        chk("rw_drop", drop_cnt_o, 0);
        issue(1'b0, 2'b10, 32'h0000_5000, 32'h0);
        push(2'b01, 32'h0BAD_F00D, 1);
        chk("rw_newid", spl_packet_id_o, 0);
        chk("rw_dest", spl_node_dest_o, 5);
        ack();
        respond(2'b10, 32'h0BAD_F00D, 4'd5, 5'd0);
        wait_resp("rw", 0);
        chk("sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
